// File: rtl/data_sync_tx_pkg.sv
// Shared types for the data_sync_tx launcher: handshake FSM states and the
// hold-counter width helper.
package data_sync_tx_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        SETUP   = 2'b01,
        ASSERT  = 2'b10,
        RELEASE = 2'b11
    } state_t;

    // Hold counter needs to reach MIN_HOLD-1; never narrower than one bit.
    function automatic int cnt_width(input int min_hold);
        return (min_hold > 1) ? $clog2(min_hold) : 1;
    endfunction

endpackage

// File: rtl/data_sync_tx_if.sv
// Upstream valid/ready word channel into the CDC launcher.
interface data_sync_tx_if #(
    parameter int BUS_WIDTH = 8
);
    logic [BUS_WIDTH-1:0] in_data;
    logic                 in_valid;
    logic                 in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/data_sync_tx_bit_sync.sv
// Single-bit multi-flop synchronizer with synchronous active-high reset.
module bit_sync #(
    parameter int NUM_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [NUM_STAGES-1:0] chain;

    // Shift the asynchronous input through the chain; only the last stage is used.
    always_ff @(posedge clk) begin
        if (rst) chain <= '0;
        else     chain <= {chain[NUM_STAGES-2:0], d};
    end

    assign q = chain[NUM_STAGES-1];
endmodule

// File: rtl/data_sync_tx.sv
// Source-domain launcher: captures a word, holds it on unsync_bus and runs a
// 4-phase req/ack handshake on bus_enable against a synchronized acknowledge.
module data_sync_tx
    import data_sync_tx_pkg::*;
#(
    parameter int BUS_WIDTH  = 8,
    parameter int NUM_STAGES = 2,
    parameter int MIN_HOLD   = 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    data_sync_tx_if.slave        in_if,
    input  logic                 ack_async,
    output logic [BUS_WIDTH-1:0] unsync_bus,
    output logic                 bus_enable,
    output logic                 busy,
    output logic                 tx_done
);
    localparam int           CW      = cnt_width(MIN_HOLD);
    localparam logic [CW-1:0] CNT_MAX = CW'(MIN_HOLD - 1);

    state_t               state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [BUS_WIDTH-1:0] bus_n;
    logic                 en_n, done_n, rdy, rdy_n;
    logic                 ack_s;

    bit_sync #(.NUM_STAGES(NUM_STAGES)) u_ack_sync (
        .clk (CLK),
        .rst (RST),
        .d   (ack_async),
        .q   (ack_s)
    );

    // Next-state and registered-output decode for the handshake FSM.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bus_n   = unsync_bus;
        en_n    = bus_enable;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                // rdy is low for the first cycle out of reset, so nothing is taken then.
                if (in_if.in_valid && rdy) begin
                    bus_n   = in_if.in_data;
                    state_n = SETUP;
                end
            end
            SETUP: begin
                en_n    = 1'b1;
                cnt_n   = '0;
                state_n = ASSERT;
            end
            ASSERT: begin
                if (ack_s && cnt == CNT_MAX) begin
                    en_n    = 1'b0;
                    cnt_n   = '0;
                    state_n = RELEASE;
                end else if (cnt != CNT_MAX) begin
                    cnt_n = cnt + 1'b1;
                end
            end
            RELEASE: begin
                if (!ack_s && cnt == CNT_MAX) begin
                    done_n  = 1'b1;
                    state_n = IDLE;
                end else if (cnt != CNT_MAX) begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        rdy_n = (state_n == IDLE);
    end

    // State and output registers; reset discards any in-flight word.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            cnt        <= '0;
            unsync_bus <= '0;
            bus_enable <= 1'b0;
            tx_done    <= 1'b0;
            rdy        <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            unsync_bus <= bus_n;
            bus_enable <= en_n;
            tx_done    <= done_n;
            rdy        <= rdy_n;
        end
    end

    assign in_if.in_ready = rdy;
    assign busy           = (state != IDLE);
endmodule
